// File: rtl/des_sbox_sequencer.sv
// Time-multiplexed DES S-box controller: issues S1..S8 lookups through one shared port
// and assembles the 32-bit substituted word. Optional Abort input via DES_SBOX_SEQ_ABORT_EN.
module des_sbox_sequencer #(
  parameter int SBOX_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] data_in,
  output logic [2:0]  sbox_sel,
  output logic [5:0]  sbox_in,
  input  logic [3:0]  sbox_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
`ifdef DES_SBOX_SEQ_ABORT_EN
  input  logic        abort,
`endif
  output logic [1:0]  state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds valid and data stable until that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_RUN = 4'(7 + SBOX_LAT);

  state_t      state, state_nxt;
  logic [3:0]  run_cnt;
  logic [47:0] hold;
  logic [2:0]  issue_k;
  logic [2:0]  cap_j;
  logic        cap_en;
  logic        abort_req;
  logic [5:0]  chunk [8];

`ifdef DES_SBOX_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // run_cnt counts RUN cycles; the issue index saturates at S8 while a registered
  // S-box drains its last result.
  assign issue_k   = (run_cnt > 4'd7) ? 3'd7 : run_cnt[2:0];
  assign cap_j     = 3'(run_cnt - 4'(SBOX_LAT));
  assign state_dbg = state;

  generate
    if (SBOX_LAT == 0) begin : g_lat0
      assign cap_en = 1'b1;
    end else begin : g_lat1
      assign cap_en = (run_cnt != 4'd0);
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      chunk[i] = hold[47-6*i -: 6];
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sbox_sel  = 3'd0;
    sbox_in   = 6'd0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        sbox_sel = issue_k;
        sbox_in  = chunk[issue_k];
        if (abort_req)                state_nxt = IDLE;
        else if (run_cnt == LAST_RUN) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (abort_req || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      run_cnt  <= 4'd0;
      hold     <= 48'd0;
      data_out <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        hold    <= data_in;
        run_cnt <= 4'd0;
      end else if (state == RUN) begin
        if (run_cnt != LAST_RUN) run_cnt <= run_cnt + 4'd1;
        if (cap_en && !abort_req) begin
          for (int i = 0; i < 8; i++) begin
            if (cap_j == 3'(i)) data_out[31-4*i -: 4] <= sbox_out;
          end
        end
      end
    end
  end

endmodule
